biquad8_coeff_loader: RTL and testbench
=======================================

Name: biquad8_coeff_loader

Overview:
Drives the 18-bit coefficient programming port (coeff_dat / coeff_wr / coeff_adr / coeff_update) of one or more biquad8_incremental instances from a host-writable shadow bank. On command it shifts coefficients into the DSP B-register cascade in reverse order. It then issues one simultaneous update strobe so every target switches coefficients on the same clock. It sits between the register-bus slave and the filter chain, in the filter clock domain.

Parameters:
NCOEFF, 2, coefficients per target, equal to the B-cascade depth (low DSP feeds high DSP).
NTARGET, 4, number of filter instances served; each has its own write strobe.
COEFF_BITS, 18, coefficient width, matching the DSP B port.
IDX_BITS, clog2(NCOEFF) (min 1), width of the coefficient index field.
TGT_BITS, clog2(NTARGET) (min 1), width of the target select field.

Ports:
clk  in  1  filter clock.
rst_n  in  1  asynchronous, active-low reset.
host_wr_i  in  1  shadow write strobe.
host_adr_i  in  TGT_BITS+IDX_BITS  {target, index} shadow address.
host_dat_i  in  COEFF_BITS  shadow write data.
host_go_i  in  1  start a load sequence (single-cycle pulse).
host_all_i  in  1  sampled with host_go_i: 1 = load all targets, 0 = load target host_adr_i[TGT].
busy_o  out  1  sequence in progress.
done_o  out  1  one-cycle pulse when the sequence completes.
err_o  out  1  sticky flag: host write or go received while busy; cleared by host_go_i accepted in IDLE.
coeff_dat_o  out  COEFF_BITS  to coeff_dat_i of all targets (shared).
coeff_wr_o  out  NTARGET  one-hot per-target write strobe.
coeff_adr_o  out  1  high while writing the upper half of the indices (idx >= NCOEFF/2).
coeff_update_o  out  1  broadcast update strobe to all targets.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM in IDLE, shadow bank cleared to 0, err_o = 0.
- Shadow write: takes effect when host_wr_i is high in IDLE; shadow[tgt][idx] <= host_dat_i. If a write and a go arrive in the same cycle, the write lands first and the load uses the new value.
- FSM states:
  - IDLE -> WR on an accepted go.
  - WR: coeff_wr_o[t] = 1, coeff_dat_o = shadow[t][idx]. Go to HOLD.
  - HOLD: coeff_wr_o = 0, coeff_dat_o held unchanged. This covers the target's registered CEB1.
  - From HOLD: idx decrements. If idx reaches 0, t advances (all-mode) and idx restarts; back to WR. After the last target go to SETTLE.
  - SETTLE: one idle cycle, nothing driven. Go to UPD.
  - UPD: coeff_update_o = 1 for one cycle. Go to DONE.
  - DONE: done_o = 1. Go to IDLE.
- Coefficient order: idx starts at NCOEFF-1 and counts down to 0. Targets go in ascending order.
- coeff_dat_o changes only on entry to WR. Outside WR/HOLD it holds the last value.
- busy_o is high from the cycle after go acceptance through the DONE cycle.
- Latency: go sampled at edge N, first WR at N+1, UPD at N+2+2*NCOEFF*K, where K = 1 or NTARGET.
- host_go_i or host_wr_i while busy: ignored, err_o set. A sequence in progress is never disturbed.
- Reset mid-sequence: strobes drop immediately. No update pulse is issued, so targets keep their old active coefficients. The shadow bank is cleared.
- Single-target go with a target number >= NTARGET: treated as a no-op. FSM stays in IDLE and err_o is set.

Optional Feature:
BQ_COEFF_READBACK_EN: when defined, adds output host_rdat_o [COEFF_BITS-1:0] = shadow[host_adr_i], registered with 1-cycle latency and valid in any state. When undefined, the port and its read mux are absent.

Decomposition:
- Package biquad8_coeff_pkg holds:
  - the FSM state encoding (IDLE, WR, HOLD, SETTLE, UPD, DONE);
  - the COEFF_BITS default;
  - an address-split helper (tgt/idx field extraction).
- One sub-module, biquad8_coeff_bank: NTARGET x NCOEFF register file with a write port and an async read port (plus the registered readback when the macro is defined). It is instantiated once.

Test Plan:
- Single-target load (NCOEFF=2): write t0 idx0=0x00100, idx1=0x3FF00; go, all=0.
  -> wr[0] with dat 0x3FF00 (adr=1), then wr[0] with 0x00100 (adr=0), each followed by a hold cycle with the same dat.
  -> update 6 cycles after go, done 1 cycle after update.
- All-target load: distinct values per target; go, all=1.
  -> Wr strobes step t0..t3 in order, 8 write pulses total, exactly one update at go+18.
- Busy protection: host_wr_i to t0 idx0=0x12345 during HOLD.
  -> Shadow unchanged, err_o=1 and stays set; the next accepted go clears it.
- Write+go same cycle: write t1 idx1=0x0ABCD together with go on t1.
  -> The first WR drives 0x0ABCD.
- Reset mid-sequence: assert rst_n=0 during the second WR.
  -> coeff_wr_o, busy_o, coeff_update_o go to 0 without waiting for a clock edge; no update pulse follows after release; shadow reads 0.
- With BQ_COEFF_READBACK_EN: write t2 idx0=0x2AAAA, then read the same address.
  -> host_rdat_o = 0x2AAAA one cycle later.

Source files
------------

// File: rtl/biquad8_coeff_pkg.sv
// Shared types and helpers for the biquad8 coefficient loader: FSM encoding,
// default coefficient width and {target, index} address field extraction.
package biquad8_coeff_pkg;

  localparam int COEFF_BITS_DEF = 18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_HOLD,
    S_SETTLE,
    S_UPD,
    S_DONE
  } state_e;

  // Shadow addresses are {target, index} with the index in the low idx_bits.
  function automatic int unsigned addr_tgt(input int unsigned adr, input int unsigned idx_bits);
    return adr >> idx_bits;
  endfunction

  function automatic int unsigned addr_idx(input int unsigned adr, input int unsigned idx_bits);
    return adr & ((32'd1 << idx_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/biquad8_coeff_loader_if.sv
// Coefficient programming bus from the loader (master) to the biquad8 filter
// chain (slave): shared data, per-target write strobes, half select, update.
interface biquad8_coeff_loader_if #(
  parameter int NTARGET    = 4,
  parameter int COEFF_BITS = biquad8_coeff_pkg::COEFF_BITS_DEF
);

  logic [COEFF_BITS-1:0] coeff_dat;
  logic [NTARGET-1:0]    coeff_wr;
  logic                  coeff_adr;
  logic                  coeff_update;

  modport master (output coeff_dat, coeff_wr, coeff_adr, coeff_update);
  modport slave  (input  coeff_dat, coeff_wr, coeff_adr, coeff_update);

endinterface

// File: rtl/biquad8_coeff_bank.sv
// NTARGET x NCOEFF shadow coefficient register file with one write port and an
// async read port; BQ_COEFF_READBACK_EN adds a registered host readback port.
module biquad8_coeff_bank
  import biquad8_coeff_pkg::*;
#(
  parameter int NCOEFF     = 2,
  parameter int NTARGET    = 4,
  parameter int COEFF_BITS = COEFF_BITS_DEF,
  parameter int IDX_BITS   = (NCOEFF > 1) ? $clog2(NCOEFF) : 1,
  parameter int TGT_BITS   = (NTARGET > 1) ? $clog2(NTARGET) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_i,
  input  logic [TGT_BITS-1:0]   wr_tgt_i,
  input  logic [IDX_BITS-1:0]   wr_idx_i,
  input  logic [COEFF_BITS-1:0] wr_dat_i,
  input  logic [TGT_BITS-1:0]   rd_tgt_i,
  input  logic [IDX_BITS-1:0]   rd_idx_i,
`ifdef BQ_COEFF_READBACK_EN
  input  logic [TGT_BITS-1:0]   rb_tgt_i,
  input  logic [IDX_BITS-1:0]   rb_idx_i,
  output logic [COEFF_BITS-1:0] rb_dat_o,
`endif
  output logic [COEFF_BITS-1:0] rd_dat_o
);

  logic [COEFF_BITS-1:0] mem_q [NTARGET][NCOEFF];
  logic                  wr_ok;
  logic                  rd_ok;

  // Addresses outside the populated bank are dropped on write and read as zero.
  assign wr_ok = ({1'b0, wr_tgt_i} < (TGT_BITS+1)'(NTARGET)) &&
                 ({1'b0, wr_idx_i} < (IDX_BITS+1)'(NCOEFF));
  assign rd_ok = ({1'b0, rd_tgt_i} < (TGT_BITS+1)'(NTARGET)) &&
                 ({1'b0, rd_idx_i} < (IDX_BITS+1)'(NCOEFF));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NTARGET; t++) begin
        for (int i = 0; i < NCOEFF; i++) begin
          mem_q[t][i] <= '0;
        end
      end
    end else if (wr_i && wr_ok) begin
      mem_q[wr_tgt_i][wr_idx_i] <= wr_dat_i;
    end
  end

  assign rd_dat_o = rd_ok ? mem_q[rd_tgt_i][rd_idx_i] : '0;

`ifdef BQ_COEFF_READBACK_EN
  logic                  rb_ok;
  logic [COEFF_BITS-1:0] rb_q;

  assign rb_ok = ({1'b0, rb_tgt_i} < (TGT_BITS+1)'(NTARGET)) &&
                 ({1'b0, rb_idx_i} < (IDX_BITS+1)'(NCOEFF));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_q <= '0;
    end else begin
      rb_q <= rb_ok ? mem_q[rb_tgt_i][rb_idx_i] : '0;
    end
  end

  assign rb_dat_o = rb_q;
`endif

endmodule

// File: rtl/biquad8_coeff_loader.sv
// Shifts shadow coefficients into the biquad8 B-register cascades (highest index
// first) and then broadcasts one update strobe. Optional: BQ_COEFF_READBACK_EN.
module biquad8_coeff_loader
  import biquad8_coeff_pkg::*;
#(
  parameter int NCOEFF     = 2,
  parameter int NTARGET    = 4,
  parameter int COEFF_BITS = COEFF_BITS_DEF,
  parameter int IDX_BITS   = (NCOEFF > 1) ? $clog2(NCOEFF) : 1,
  parameter int TGT_BITS   = (NTARGET > 1) ? $clog2(NTARGET) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         host_wr_i,
  input  logic [TGT_BITS+IDX_BITS-1:0] host_adr_i,
  input  logic [COEFF_BITS-1:0]        host_dat_i,
  input  logic                         host_go_i,
  input  logic                         host_all_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
`ifdef BQ_COEFF_READBACK_EN
  output logic [COEFF_BITS-1:0]        host_rdat_o,
`endif
  biquad8_coeff_loader_if.master       coeff_o
);

  localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(NCOEFF - 1);
  localparam logic [IDX_BITS-1:0] IDX_HALF = IDX_BITS'(NCOEFF / 2);
  localparam logic [TGT_BITS-1:0] TGT_LAST = TGT_BITS'(NTARGET - 1);

  state_e                state_q, state_d;
  logic [TGT_BITS-1:0]   tgt_q, tgt_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic                  all_q, all_d;
  logic                  err_q, err_d;
  logic [COEFF_BITS-1:0] dat_q, dat_d;

  logic [TGT_BITS-1:0]   host_tgt;
  logic [IDX_BITS-1:0]   host_idx;
  logic                  idle;
  logic                  tgt_ok;
  logic                  go_ok;
  logic                  shadow_wr;
  logic [COEFF_BITS-1:0] shadow_rd;

  assign host_tgt  = TGT_BITS'(addr_tgt(32'(host_adr_i), IDX_BITS));
  assign host_idx  = IDX_BITS'(addr_idx(32'(host_adr_i), IDX_BITS));
  assign idle      = (state_q == S_IDLE);
  assign tgt_ok    = ({1'b0, host_tgt} < (TGT_BITS+1)'(NTARGET));
  assign go_ok     = idle && host_go_i && (host_all_i || tgt_ok);
  assign shadow_wr = idle && host_wr_i;

  biquad8_coeff_bank #(
    .NCOEFF    (NCOEFF),
    .NTARGET   (NTARGET),
    .COEFF_BITS(COEFF_BITS),
    .IDX_BITS  (IDX_BITS),
    .TGT_BITS  (TGT_BITS)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_i    (shadow_wr),
    .wr_tgt_i(host_tgt),
    .wr_idx_i(host_idx),
    .wr_dat_i(host_dat_i),
    .rd_tgt_i(tgt_q),
    .rd_idx_i(idx_q),
`ifdef BQ_COEFF_READBACK_EN
    .rb_tgt_i(host_tgt),
    .rb_idx_i(host_idx),
    .rb_dat_o(host_rdat_o),
`endif
    .rd_dat_o(shadow_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      idx_q   <= '0;
      all_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      idx_q   <= idx_d;
      all_q   <= all_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // A shadow write in the go cycle lands before the first WR reads the bank,
  // so the load naturally sees the new value without any bypass.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    idx_d   = idx_q;
    all_d   = all_q;
    err_d   = err_q;
    dat_d   = dat_q;
    if (!idle && (host_wr_i || host_go_i)) begin
      err_d = 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (go_ok) begin
          state_d = S_WR;
          tgt_d   = host_all_i ? '0 : host_tgt;
          idx_d   = IDX_LAST;
          all_d   = host_all_i;
          err_d   = 1'b0;
        end else if (host_go_i) begin
          err_d = 1'b1;
        end
      end
      S_WR: begin
        dat_d   = shadow_rd;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (idx_q != '0) begin
          idx_d   = idx_q - IDX_BITS'(1);
          state_d = S_WR;
        end else if (all_q && (tgt_q != TGT_LAST)) begin
          tgt_d   = tgt_q + TGT_BITS'(1);
          idx_d   = IDX_LAST;
          state_d = S_WR;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: state_d = S_UPD;
      S_UPD:    state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    coeff_o.coeff_wr     = '0;
    coeff_o.coeff_dat    = dat_q;
    coeff_o.coeff_adr    = 1'b0;
    coeff_o.coeff_update = 1'b0;
    done_o               = 1'b0;
    busy_o               = !idle;
    err_o                = err_q;
    case (state_q)
      S_WR: begin
        coeff_o.coeff_wr  = NTARGET'(1) << tgt_q;
        coeff_o.coeff_dat = shadow_rd;
        coeff_o.coeff_adr = (idx_q >= IDX_HALF);
      end
      S_HOLD:  coeff_o.coeff_adr = (idx_q >= IDX_HALF);
      S_UPD:   coeff_o.coeff_update = 1'b1;
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Self-checking bench for biquad8_coeff_loader against a shadow-array model;
// covers the readback port too when BQ_COEFF_READBACK_EN is defined.
`timescale 1ns/1ps
module tb_biquad8_coeff_loader;

  localparam int NCOEFF  = 2;
  localparam int NTARGET = 4;
  localparam int CB      = 18;
  localparam int IDXB    = 1;
  localparam int TGTB    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 host_wr_i = 1'b0;
  logic [TGTB+IDXB-1:0] host_adr_i = '0;
  logic [CB-1:0]        host_dat_i = '0;
  logic                 host_go_i = 1'b0;
  logic                 host_all_i = 1'b0;
  logic                 busy_o, done_o, err_o;
`ifdef BQ_COEFF_READBACK_EN
  logic [CB-1:0]        host_rdat_o;
`endif

  int tests_run = 0;
  int failed = 0;

  logic [CB-1:0] model [NTARGET][NCOEFF];
  int            exp_t[$];
  int            exp_i[$];

  int            obs_cyc[$];
  logic [3:0]    obs_wr[$];
  logic [CB-1:0] obs_dat[$];
  logic          obs_adr[$];
  logic [CB-1:0] obs_hold[$];
  int            upd_cnt, upd_cyc, done_cyc, busy_low;

  always #5 clk = ~clk;

  biquad8_coeff_loader_if #(.NTARGET(NTARGET), .COEFF_BITS(CB)) cif ();

  biquad8_coeff_loader #(.NCOEFF(NCOEFF), .NTARGET(NTARGET), .COEFF_BITS(CB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host_wr_i  (host_wr_i),
    .host_adr_i (host_adr_i),
    .host_dat_i (host_dat_i),
    .host_go_i  (host_go_i),
    .host_all_i (host_all_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
`ifdef BQ_COEFF_READBACK_EN
    .host_rdat_o(host_rdat_o),
`endif
    .coeff_o    (cif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int t, input int i, input logic [CB-1:0] d);
    host_wr_i  = 1'b1;
    host_adr_i = 3'((t << IDXB) | i);
    host_dat_i = d;
    tick();
    host_wr_i  = 1'b0;
    model[t][i] = d;
  endtask

  task automatic start_go(input bit all, input int t);
    host_go_i  = 1'b1;
    host_all_i = all;
    host_adr_i = 3'(t << IDXB);
    tick();
    host_go_i  = 1'b0;
    host_all_i = 1'b0;
  endtask

  // Expected write order: ascending targets, indices from NCOEFF-1 down to 0.
  function automatic void build_expected(input bit all, input int t);
    exp_t.delete();
    exp_i.delete();
    for (int tt = 0; tt < NTARGET; tt++) begin
      if (all || tt == t) begin
        for (int i = NCOEFF - 1; i >= 0; i--) begin
          exp_t.push_back(tt);
          exp_i.push_back(i);
        end
      end
    end
  endfunction

  // Records the bus trace from cycle first_cyc after go until done (bounded).
  task automatic capture(input int first_cyc);
    logic prev_wr;
    obs_cyc.delete(); obs_wr.delete(); obs_dat.delete(); obs_adr.delete(); obs_hold.delete();
    upd_cnt = 0; upd_cyc = -1; done_cyc = -1; busy_low = 0; prev_wr = 1'b0;
    for (int cyc = first_cyc; cyc <= 60; cyc++) begin
      if (prev_wr) obs_hold.push_back(cif.coeff_dat);
      if (cif.coeff_wr != '0) begin
        obs_cyc.push_back(cyc);
        obs_wr.push_back(cif.coeff_wr);
        obs_dat.push_back(cif.coeff_dat);
        obs_adr.push_back(cif.coeff_adr);
      end
      if (cif.coeff_update) begin
        upd_cnt++;
        upd_cyc = cyc;
      end
      if (!busy_o) busy_low++;
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
      prev_wr = (cif.coeff_wr != '0);
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({busy_o, done_o, err_o} !== 3'b000) begin
      failed++;
      $display("[TB] FAIL reset_status: got %b expected 000", {busy_o, done_o, err_o});
    end
    tests_run++;
    if ({cif.coeff_wr, cif.coeff_adr, cif.coeff_update} !== 6'b0) begin
      failed++;
      $display("[TB] FAIL reset_strobes: got %b expected 0", {cif.coeff_wr, cif.coeff_adr, cif.coeff_update});
    end
    tests_run++;
    if (cif.coeff_dat !== 18'h0) begin
      failed++;
      $display("[TB] FAIL reset_dat: got %h expected 0", cif.coeff_dat);
    end
    rst_n = 1'b1;
    for (int t = 0; t < NTARGET; t++)
      for (int i = 0; i < NCOEFF; i++) model[t][i] = '0;
    tick();
  endtask

  task automatic test_single_target();
    int k;
    host_write(0, 0, 18'h00100);
    host_write(0, 1, 18'h3FF00);
    build_expected(1'b0, 0);
    start_go(1'b0, 0);
    capture(1);
    k = exp_t.size() / NCOEFF;
    tests_run++;
    if (obs_wr.size() !== exp_t.size()) begin
      failed++;
      $display("[TB] FAIL single_count: got %0d expected %0d", obs_wr.size(), exp_t.size());
    end
    for (int n = 0; n < exp_t.size() && n < obs_wr.size() && n < obs_hold.size(); n++) begin
      tests_run++;
      if (obs_wr[n] !== 4'(1 << exp_t[n]) || obs_cyc[n] !== 1 + 2 * n) begin
        failed++;
        $display("[TB] FAIL single_strobe%0d: got %b@%0d expected %b@%0d", n, obs_wr[n], obs_cyc[n], 4'(1 << exp_t[n]), 1 + 2 * n);
      end
      tests_run++;
      if (obs_dat[n] !== model[exp_t[n]][exp_i[n]] || obs_hold[n] !== obs_dat[n] ||
          obs_adr[n] !== (exp_i[n] >= NCOEFF / 2)) begin
        failed++;
        $display("[TB] FAIL single_data%0d: got %h/%h adr %b expected %h adr %b", n, obs_dat[n], obs_hold[n], obs_adr[n], model[exp_t[n]][exp_i[n]], exp_i[n] >= NCOEFF / 2);
      end
    end
    tests_run++;
    if (upd_cnt !== 1 || upd_cyc !== 2 + 2 * NCOEFF * k || done_cyc !== 3 + 2 * NCOEFF * k) begin
      failed++;
      $display("[TB] FAIL single_timing: got upd %0dx@%0d done@%0d expected 1x@%0d done@%0d", upd_cnt, upd_cyc, done_cyc, 2 + 2 * NCOEFF * k, 3 + 2 * NCOEFF * k);
    end
    tests_run++;
    if (busy_low !== 0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      failed++;
      $display("[TB] FAIL single_busy: got lowcycles %0d busy %b done %b expected 0 0 0", busy_low, busy_o, done_o);
    end
  endtask

  task automatic test_all_targets(input int iters, input bit rand_mode);
    bit all;
    int tsel, k;
    for (int it = 0; it < iters; it++) begin
      if (rand_mode) begin
        for (int w = 0; w < int'($urandom_range(1, 5)); w++)
          host_write(int'($urandom_range(0, NTARGET - 1)), int'($urandom_range(0, NCOEFF - 1)), 18'($urandom));
        all  = 1'($urandom);
        tsel = int'($urandom_range(0, NTARGET - 1));
      end else begin
        for (int t = 0; t < NTARGET; t++)
          for (int i = 0; i < NCOEFF; i++) host_write(t, i, 18'(((t + 1) << 12) | ((i + 1) << 4) | $urandom_range(0, 15)));
        all  = 1'b1;
        tsel = 0;
      end
      build_expected(all, tsel);
      start_go(all, tsel);
      capture(1);
      k = all ? NTARGET : 1;
      tests_run++;
      if (obs_wr.size() !== exp_t.size()) begin
        failed++;
        $display("[TB] FAIL load%0d_count: got %0d expected %0d", it, obs_wr.size(), exp_t.size());
      end
      for (int n = 0; n < exp_t.size() && n < obs_wr.size() && n < obs_hold.size(); n++) begin
        tests_run++;
        if (obs_wr[n] !== 4'(1 << exp_t[n]) || obs_cyc[n] !== 1 + 2 * n ||
            obs_dat[n] !== model[exp_t[n]][exp_i[n]] || obs_hold[n] !== obs_dat[n] ||
            obs_adr[n] !== (exp_i[n] >= NCOEFF / 2)) begin
          failed++;
          $display("[TB] FAIL load%0d_wr%0d: got %b@%0d %h/%h adr %b expected %b@%0d %h adr %b", it, n, obs_wr[n], obs_cyc[n], obs_dat[n], obs_hold[n], obs_adr[n], 4'(1 << exp_t[n]), 1 + 2 * n, model[exp_t[n]][exp_i[n]], exp_i[n] >= NCOEFF / 2);
        end
      end
      tests_run++;
      if (upd_cnt !== 1 || upd_cyc !== 2 + 2 * NCOEFF * k || done_cyc !== 3 + 2 * NCOEFF * k) begin
        failed++;
        $display("[TB] FAIL load%0d_timing: got upd %0dx@%0d done@%0d expected 1x@%0d done@%0d", it, upd_cnt, upd_cyc, done_cyc, 2 + 2 * NCOEFF * k, 3 + 2 * NCOEFF * k);
      end
    end
  endtask

  task automatic test_busy_protect();
    host_write(0, 0, 18'h00ABC);
    start_go(1'b0, 0);
    tick();
    host_wr_i  = 1'b1;
    host_adr_i = 3'b000;
    host_dat_i = 18'h12345;
    tick();
    host_wr_i  = 1'b0;
    capture(3);
    tests_run++;
    if (err_o !== 1'b1 || upd_cyc !== 6) begin
      failed++;
      $display("[TB] FAIL busy_wr_err: got err %b upd@%0d expected err 1 upd@6", err_o, upd_cyc);
    end
    tick();
    tick();
    tests_run++;
    if (err_o !== 1'b1) begin
      failed++;
      $display("[TB] FAIL busy_err_sticky: got %b expected 1", err_o);
    end
    start_go(1'b0, 0);
    tests_run++;
    if (err_o !== 1'b0) begin
      failed++;
      $display("[TB] FAIL busy_err_clear: got %b expected 0", err_o);
    end
    tick();
    host_go_i  = 1'b1;
    host_all_i = 1'b1;
    tick();
    host_go_i  = 1'b0;
    host_all_i = 1'b0;
    capture(3);
    tests_run++;
    if (obs_dat.size() !== 1 || obs_dat[0] !== model[0][0]) begin
      failed++;
      $display("[TB] FAIL busy_shadow: got %0d writes dat %h expected 1 write dat %h", obs_dat.size(), (obs_dat.size() > 0) ? obs_dat[0] : 18'h0, model[0][0]);
    end
    tests_run++;
    if (err_o !== 1'b1 || upd_cnt !== 1 || upd_cyc !== 6) begin
      failed++;
      $display("[TB] FAIL busy_go_ignored: got err %b upd %0dx@%0d expected err 1 upd 1x@6", err_o, upd_cnt, upd_cyc);
    end
  endtask

  task automatic test_write_go_same();
    host_wr_i  = 1'b1;
    host_go_i  = 1'b1;
    host_all_i = 1'b0;
    host_adr_i = 3'b011;
    host_dat_i = 18'h0ABCD;
    tick();
    host_wr_i = 1'b0;
    host_go_i = 1'b0;
    model[1][1] = 18'h0ABCD;
    tests_run++;
    if (err_o !== 1'b0) begin
      failed++;
      $display("[TB] FAIL wrgo_err_clear: got %b expected 0", err_o);
    end
    capture(1);
    tests_run++;
    if (obs_wr.size() < 1 || obs_wr[0] !== 4'b0010 || obs_dat[0] !== 18'h0ABCD) begin
      failed++;
      $display("[TB] FAIL wrgo_first: got %b dat %h expected 0010 dat 0abcd", (obs_wr.size() > 0) ? obs_wr[0] : 4'h0, (obs_dat.size() > 0) ? obs_dat[0] : 18'h0);
    end
  endtask

  task automatic test_reset_mid();
    int upd_seen;
    int nonzero;
    start_go(1'b1, 0);
    tick();
    tick();
    tests_run++;
    if (cif.coeff_wr !== 4'b0001) begin
      failed++;
      $display("[TB] FAIL rstmid_second_wr: got %b expected 0001", cif.coeff_wr);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({cif.coeff_wr, busy_o, cif.coeff_update} !== 6'b0) begin
      failed++;
      $display("[TB] FAIL rstmid_async: got wr %b busy %b upd %b expected all 0", cif.coeff_wr, busy_o, cif.coeff_update);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < NTARGET; t++)
      for (int i = 0; i < NCOEFF; i++) model[t][i] = '0;
    upd_seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (cif.coeff_update || busy_o) upd_seen++;
      tick();
    end
    tests_run++;
    if (upd_seen !== 0) begin
      failed++;
      $display("[TB] FAIL rstmid_no_update: got %0d active cycles expected 0", upd_seen);
    end
    start_go(1'b1, 0);
    capture(1);
    nonzero = 0;
    foreach (obs_dat[n]) if (obs_dat[n] !== 18'h0) nonzero++;
    tests_run++;
    if (obs_dat.size() !== NTARGET * NCOEFF || nonzero !== 0) begin
      failed++;
      $display("[TB] FAIL rstmid_shadow_clear: got %0d writes %0d nonzero expected %0d writes 0 nonzero", obs_dat.size(), nonzero, NTARGET * NCOEFF);
    end
  endtask

`ifdef BQ_COEFF_READBACK_EN
  task automatic test_readback();
    host_write(2, 0, 18'h2AAAA);
    tick();
    tests_run++;
    if (host_rdat_o !== 18'h2AAAA) begin
      failed++;
      $display("[TB] FAIL readback_t2i0: got %h expected 2aaaa", host_rdat_o);
    end
    host_adr_i = 3'b011;
    tick();
    tests_run++;
    if (host_rdat_o !== model[1][1]) begin
      failed++;
      $display("[TB] FAIL readback_t1i1: got %h expected %h", host_rdat_o, model[1][1]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_target();
    test_all_targets(1, 1'b0);
    test_busy_protect();
    test_write_go_same();
    test_all_targets(6, 1'b1);
`ifdef BQ_COEFF_READBACK_EN
    test_readback();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
